// File: rtl/alu_operand_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_operand_issuer                                           |
// | Description : Register-file front end that feeds a combinational MIPS ALU, |
// |               captures its result and flags, and retires with writeback.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_operand_issuer #(
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int SUPPRESS_OVF_WB    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        preload_en,
    input  logic [4:0]  preload_addr,
    input  logic [31:0] preload_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        branch_taken,
    output logic        mem_addr_valid,
    output logic [31:0] mem_addr,
    output logic        ovf_exc,
    output logic [2:0]  flags_q
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_WB   = 2'd2;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;

    localparam logic c_ZERO_HW  = (ZERO_REG_HARDWIRED != 0);
    localparam logic c_SUPP_OVF = (SUPPRESS_OVF_WB != 0);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_regs [32];

    logic [31:0] r_result;
    logic [2:0]  r_flags;
    logic        r_wb_en;
    logic [4:0]  r_wb_addr;
    logic        r_branch;
    logic        r_mem;
    logic        r_ovf;

    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_pre_we;

    logic [5:0]  w_ex_op;
    logic [5:0]  w_ex_fn;
    logic        w_has_dest;
    logic [4:0]  w_dest;
    logic        w_trap_op;
    logic        w_is_br;
    logic        w_is_mem;
    logic        w_ovf;
    logic        w_wb_en;

    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_pre_we = preload_en && !(c_ZERO_HW && preload_addr == 5'd0);

    // Operand reads bypass a same-cycle preload so the new value is issued.
    always_comb begin
        w_rs_val = r_regs[w_rs];
        w_rt_val = r_regs[w_rt];
        if (w_pre_we && preload_addr == w_rs) w_rs_val = preload_data;
        if (w_pre_we && preload_addr == w_rt) w_rt_val = preload_data;
        if (c_ZERO_HW && w_rs == 5'd0) w_rs_val = '0;
        if (c_ZERO_HW && w_rt == 5'd0) w_rt_val = '0;
        dbg_data = (c_ZERO_HW && dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];
    end

    // Shifts take their data from rt; immediate shifts have no second operand.
    always_comb begin
        w_op_a = w_rs_val;
        w_op_b = w_rt_val;
        if (instr[31:26] == c_OP_RTYPE) begin
            case (instr[5:0])
                6'h00, 6'h02, 6'h03: begin w_op_a = w_rt_val; w_op_b = '0;       end
                6'h04, 6'h06, 6'h07: begin w_op_a = w_rt_val; w_op_b = w_rs_val; end
                default: ;
            endcase
        end
    end

    assign w_ex_op = alu_instruction[31:26];
    assign w_ex_fn = alu_instruction[5:0];

    always_comb begin
        w_has_dest = 1'b0;
        w_dest     = 5'd0;
        w_trap_op  = 1'b0;
        w_is_br    = 1'b0;
        w_is_mem   = 1'b0;
        if (w_ex_op == c_OP_RTYPE) begin
            case (w_ex_fn)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h2A, 6'h2B: begin
                    w_has_dest = 1'b1;
                    w_dest     = alu_instruction[15:11];
                    w_trap_op  = (w_ex_fn == c_FN_ADD) || (w_ex_fn == c_FN_SUB);
                end
                default: ;
            endcase
        end else begin
            case (w_ex_op)
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                    w_has_dest = 1'b1;
                    w_dest     = alu_instruction[20:16];
                    w_trap_op  = (w_ex_op == c_OP_ADDI);
                end
                c_OP_BEQ, c_OP_BNE: w_is_br  = 1'b1;
                c_OP_LW,  c_OP_SW:  w_is_mem = 1'b1;
                default: ;
            endcase
        end
        w_ovf   = w_trap_op && alu_flags[0];
        w_wb_en = w_has_dest && !(c_ZERO_HW && w_dest == 5'd0) && !(c_SUPP_OVF && w_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (instr_valid) w_state_next = c_EXEC;
            c_EXEC:  w_state_next = c_WB;
            c_WB:    w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        instr_ready    = (r_state == c_IDLE);
        done           = (r_state == c_WB);
        wb_en          = done && r_wb_en;
        branch_taken   = done && r_branch;
        mem_addr_valid = done && r_mem;
        ovf_exc        = done && r_ovf;
        wb_addr        = r_wb_addr;
        wb_data        = r_result;
        mem_addr       = r_result;
        flags_q        = r_flags;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_pre_we) r_regs[preload_addr] <= preload_data;
        end else if (r_state == c_WB && r_wb_en) begin
            r_regs[r_wb_addr] <= r_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_instruction <= '0;
            alu_regA        <= '0;
            alu_regB        <= '0;
            r_result        <= '0;
            r_flags         <= '0;
            r_wb_en         <= 1'b0;
            r_wb_addr       <= '0;
            r_branch        <= 1'b0;
            r_mem           <= 1'b0;
            r_ovf           <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (instr_valid) begin
                alu_instruction <= instr;
                alu_regA        <= w_op_a;
                alu_regB        <= w_op_b;
            end
        end else if (r_state == c_EXEC) begin
            r_result  <= alu_result;
            r_flags   <= alu_flags;
            r_wb_en   <= w_wb_en;
            r_wb_addr <= w_dest;
            r_branch  <= w_is_br && alu_flags[2];
            r_mem     <= w_is_mem;
            r_ovf     <= w_ovf;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_issuer.md
Name: alu_operand_issuer

Overview:
- Sequential front end for the combinational MIPS `alu`.
- Owns a 32x32 register file and accepts one instruction at a time over a valid/ready handshake.
- Drives the ALU instruction/regA/regB inputs from the register file, captures the result and flags, and writes the result back to the destination register.
- Reports branch outcome, memory address, overflow exception and completion to the surrounding datapath.

Parameters:
- `ZERO_REG_HARDWIRED`, default 1: register 0 always reads 0 and ignores writes.
- `SUPPRESS_OVF_WB`, default 1: add/addi/sub with the overflow flag set do not write back.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  block idle; can accept an instruction
- `instr`  in  32  MIPS instruction word
- `preload_en`  in  1  direct register write; honoured only in IDLE
- `preload_addr`  in  5  register index for preload
- `preload_data`  in  32  preload value
- `dbg_addr`  in  5  debug read index
- `dbg_data`  out  32  combinational read of R[`dbg_addr`]
- `alu_instruction`  out  32  to `alu` instruction input
- `alu_regA`  out  32  to `alu` regA input
- `alu_regB`  out  32  to `alu` regB input
- `alu_result`  in  32  from `alu` result
- `alu_flags`  in  3  from `alu`: [2] zero, [1] negative, [0] overflow
- `done`  out  1  one-cycle pulse when an instruction retires
- `wb_en`  out  1  with `done`: a register was written
- `wb_addr`  out  5  register written
- `wb_data`  out  32  value written
- `branch_taken`  out  1  with `done`: beq/bne condition met
- `mem_addr_valid`  out  1  with `done`: lw/sw address available
- `mem_addr`  out  32  ALU-computed address
- `ovf_exc`  out  1  with `done`: overflow trap on add/addi/sub
- `flags_q`  out  3  flags of the last retired instruction

Behaviour:
- **Reset (async, immediate):**
  - State → IDLE; all 32 registers → 0.
  - `alu_instruction`/`alu_regA`/`alu_regB` → 0; `flags_q` → 0.
  - `done`, `wb_en`, `branch_taken`, `mem_addr_valid`, `ovf_exc` → 0; `wb_addr` → 0, `wb_data` → 0, `mem_addr` → 0.
  - `instr_ready` → 1 after reset deasserts.
  - Reset mid-instruction abandons it: no writeback, no `done`.
- **States:** IDLE → EXEC → WB → IDLE.
- **IDLE:**
  - `instr_ready`=1.
  - `instr_valid`=1 at an edge latches `instr` and R[rs], R[rt] into the `alu_*` registers and moves to EXEC.
  - `preload_en` in IDLE writes R[`preload_addr`].
  - If `instr_valid` and `preload_en` are both 1, the preload writes first and the operand read sees the new value (write-through bypass).
- **EXEC:**
  - `instr_ready`=0; the `alu_*` outputs are stable for the whole cycle.
  - At the edge: capture `alu_result` and `alu_flags`, compute writeback controls, move to WB.
- **WB:**
  - Perform the register write; pulse `done` with `wb_*`, `branch_taken`, `mem_addr*`, `ovf_exc` valid for exactly this cycle.
  - Move to IDLE.
  - Latency: accept edge to `done` = 2 cycles; throughput 1 instruction per 3 cycles.
- **Operand steering (decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], func=[5:0]):**
  - sll/srl/sra (op 0, func 00/02/03): regA=R[rt], regB=0.
  - sllv/srlv/srav (func 04/06/07): regA=R[rt], regB=R[rs].
  - All others: regA=R[rs], regB=R[rt].
- **Writeback destination:**
  - R-type ALU ops: rd.
  - addi/addiu/andi/ori/xori/slti/sltiu: rt.
  - beq/bne/lw/sw: no write.
  - `wb_en`=0 if the destination is 0 and `ZERO_REG_HARDWIRED`=1.
- **Overflow:**
  - add/addi/sub with flags[0]=1: `ovf_exc`=1.
  - `wb_en`=0 if `SUPPRESS_OVF_WB`=1.
  - addu/addiu/subu never trap.
- **Branches:** beq/bne set `branch_taken` = flags[2]; the ALU zero flag encodes "condition met" for both.
- **Memory ops:** lw/sw set `mem_addr_valid`=1 and `mem_addr`=`alu_result`.
- **Unrecognised opcode/func:**
  - Retires with `done`.
  - All of `wb_en`, `branch_taken`, `mem_addr_valid`, `ovf_exc` are 0.
  - `flags_q` is still updated.
- **Register 0:** always reads 0 with `ZERO_REG_HARDWIRED`=1, including on the bypass and debug ports.
- **Ignored inputs:** `instr_valid` while busy is ignored (not queued); `preload_en` while busy is ignored.

Test Plan:
1. Preload R1=0x40000000, R2=0x40000000; issue add rs=1,rt=2,rd=8 → `done` 2 cycles after accept, `ovf_exc`=1, `wb_en`=0, R8 stays 0, `flags_q`[0]=1.
2. Preload R1=9, R2=4; issue addu rd=10 → `wb_en`=1, `wb_addr`=10, `wb_data`=0x0000000D, `dbg_data`(10)=0x0000000D after WB.
3. Preload R1=3; issue addi rs=1,rt=9,imm=13 → R9=0x00000010; then addi rt=0 → `wb_en`=0, R0 reads 0.
4. Preload R1=8, R2=6; issue bne rs=1,rt=2 → `branch_taken`=1, `wb_en`=0; beq same operands → `branch_taken`=0.
5. Preload R0 unchanged, R1=0x0000000D, R2=0xEA618000; issue srav rs=1,rt=2,rd=13 → `alu_regA`=0xEA618000, `alu_regB`=0x0000000D during EXEC, R13=0xFFFF530C.
6. Assert `reset` during EXEC of an addu to rd=10 → outputs clear at once, no `done`, R10 reads 0; `instr_valid` held during busy cycles is not accepted until `instr_ready`=1.
